// File: rtl/wave_sample_sequencer.sv
// Turns each rising edge of the divided clock into one 8-bit waveform sample.
// Define WAVE_SINE_EN to add the quarter-wave sine ROM; otherwise shape 3 repeats triangle.
module wave_sample_sequencer (
    input  logic       Clk_in,
    input  logic       Rst,
    input  logic       Clk_div,
    input  logic       En,
    input  logic [1:0] shape,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       period_done
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       s3_q, s3_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] sample_q, sample_d;
    logic       sample_valid_q, sample_valid_d;
    logic       period_done_q, period_done_d;

    logic       edge_det;
    logic [7:0] square_val;
    logic [7:0] tri_val;
    logic [7:0] shape_val;

    assign edge_det = s2_q & ~s3_q;

    always_comb begin
        square_val = idx_q[7] ? 8'd0 : 8'd255;
        // 2*(255-idx) is the bitwise complement shifted left
        tri_val    = idx_q[7] ? {~idx_q[6:0], 1'b0} : {idx_q[6:0], 1'b0};
    end

`ifdef WAVE_SINE_EN
    // round(128 + 127*sin(2*pi*i/256)) for i = 0..63
    localparam logic [7:0] SINE_ROM [0:63] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd144, 8'd147, 8'd150,
        8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174,
        8'd177, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd193, 8'd196,
        8'd199, 8'd201, 8'd204, 8'd206, 8'd209, 8'd211, 8'd213, 8'd216,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd239, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
    };

    logic [5:0] rom_addr;
    logic       rom_peak;
    logic [7:0] sine_mag;
    logic [7:0] sine_val;

    // Falling quadrants read 64-a; a==0 there is the crest, which lies outside the ROM.
    always_comb begin
        rom_addr = idx_q[6] ? (6'd0 - idx_q[5:0]) : idx_q[5:0];
        rom_peak = idx_q[6] && (idx_q[5:0] == 6'd0);
        sine_mag = rom_peak ? 8'd255 : SINE_ROM[rom_addr];
        sine_val = idx_q[7] ? 8'(9'd256 - {1'b0, sine_mag}) : sine_mag;
    end
`endif

    always_comb begin
        case (shape)
            2'd0:    shape_val = square_val;
            2'd1:    shape_val = idx_q;
            2'd2:    shape_val = tri_val;
`ifdef WAVE_SINE_EN
            default: shape_val = sine_val;
`else
            default: shape_val = tri_val;
`endif
        endcase
    end

    always_comb begin
        s1_d           = Clk_div;
        s2_d           = s1_q;
        s3_d           = s2_q;
        idx_d          = idx_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        period_done_d  = 1'b0;
        if (edge_det && En) begin
            sample_d       = shape_val;
            idx_d          = idx_q + 8'd1;
            sample_valid_d = 1'b1;
            period_done_d  = (idx_q == 8'd255);
        end
    end

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            idx_q          <= 8'd0;
            sample_q       <= 8'd0;
            sample_valid_q <= 1'b0;
            period_done_q  <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            idx_q          <= idx_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            period_done_q  <= period_done_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign period_done  = period_done_q;

endmodule

// File: tb/tb_wave_sample_sequencer.sv
// Scoreboard bench for wave_sample_sequencer: expected samples are queued when a
// Clk_div rising edge is driven and popped when sample_valid is seen.
module tb_wave_sample_sequencer;

    logic       Clk_in  = 1'b0;
    logic       Rst     = 1'b1;
    logic       Clk_div = 1'b0;
    logic       En      = 1'b0;
    logic [1:0] shape   = 2'd0;
    logic [7:0] sample;
    logic       sample_valid;
    logic       period_done;

    wave_sample_sequencer dut (
        .Clk_in       (Clk_in),
        .Rst          (Rst),
        .Clk_div      (Clk_div),
        .En           (En),
        .shape        (shape),
        .sample       (sample),
        .sample_valid (sample_valid),
        .period_done  (period_done)
    );

    always #5 Clk_in = ~Clk_in;

    int         checks = 0;
    int         errors = 0;
    int         m_idx  = 0;
    int         valid_count = 0;
    int         pd_count    = 0;
    logic [8:0] sb[$];
    logic [7:0] rx_log[$];

    function automatic logic [7:0] model_f(input int sh, input int i);
        real r;
        case (sh)
            0: return (i < 128) ? 8'd255 : 8'd0;
            1: return 8'(i);
            2: return (i < 128) ? 8'(2 * i) : 8'(2 * (255 - i));
            default: begin
`ifdef WAVE_SINE_EN
                r = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
                return 8'(int'($floor(r + 0.5)));
`else
                r = 0.0;
                return (i < 128) ? 8'(2 * i) : 8'(2 * (255 - i));
`endif
            end
        endcase
    endfunction

    // Sample-side scoreboard: every valid pulse must match the oldest expected entry.
    always @(negedge Clk_in) begin
        logic [8:0] exp_v;
        if (sample_valid === 1'b1) begin
            valid_count++;
            if (period_done === 1'b1) pd_count++;
            rx_log.push_back(sample);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got sample=%0d pd=%0b, required no sample_valid", sample, period_done);
            end else begin
                exp_v = sb.pop_front();
                if ({period_done, sample} !== exp_v) begin
                    errors++;
                    $display("FAIL sample_check: got sample=%0d pd=%0b, required sample=%0d pd=%0b",
                             sample, period_done, exp_v[7:0], exp_v[8]);
                end else begin
                    $display("sample %0d pd=%0b ok", sample, period_done);
                end
            end
        end else if (period_done === 1'b1) begin
            errors++;
            $display("FAIL pd_without_valid: got period_done=1, required 0");
        end
    end

    task automatic step();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic push_expected();
        sb.push_back({(m_idx == 255), model_f(int'(shape), m_idx)});
        m_idx = (m_idx + 1) % 256;
    endtask

    task automatic pulse(input int h);
        Clk_div = 1'b1;
        if (En) push_expected();
        repeat (h) step();
        Clk_div = 1'b0;
        repeat (h) step();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending samples, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        Clk_div = 1'b0;
        Rst = 1'b1;
        sb.delete();
        step();
        step();
        Rst = 1'b0;
        m_idx = 0;
        step();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        step();
        step();
        @(negedge Clk_in);
        checks++;
        if (sample !== 8'd0) begin errors++; $display("FAIL reset_sample: got %0d, required 0", sample); end
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", sample_valid); end
        checks++;
        if (period_done !== 1'b0) begin errors++; $display("FAIL reset_pd: got %0b, required 0", period_done); end
        step();
        Rst = 1'b0;
        m_idx = 0;
        step();
    endtask

    task automatic test_latency();
        logic got [1:4];
        int vc;
        shape = 2'd1;
        En = 1'b1;
        vc = valid_count;
        Clk_div = 1'b1;
        push_expected();
        @(negedge Clk_in);
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk_in);
            got[i] = sample_valid;
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (got[i] !== (i == 3)) begin
                errors++;
                $display("FAIL latency_k+%0d: got valid=%0b, required %0b", i, got[i], (i == 3));
            end
        end
        step();
        Clk_div = 1'b0;
        repeat (6) step();
        checks++;
        if (valid_count - vc !== 1) begin
            errors++;
            $display("FAIL one_pulse_per_edge: got %0d pulses, required 1", valid_count - vc);
        end
        wait_drain();
    endtask

    task automatic test_sawtooth();
        do_reset();
        shape = 2'd1;
        En = 1'b1;
        rx_log.delete();
        pd_count = 0;
        repeat (257) pulse(3);
        wait_drain();
        checks++;
        if (rx_log.size() != 257) begin errors++; $display("FAIL saw_count: got %0d, required 257", rx_log.size()); end
        checks++;
        if (pd_count != 1) begin errors++; $display("FAIL saw_pd_count: got %0d, required 1", pd_count); end
        checks++;
        if (rx_log[255] !== 8'd255) begin errors++; $display("FAIL saw_last: got %0d, required 255", rx_log[255]); end
        checks++;
        if (rx_log[256] !== 8'd0) begin errors++; $display("FAIL saw_wrap: got %0d, required 0", rx_log[256]); end
    endtask

    task automatic test_triangle();
        int vc;
        int pos [4] = '{0, 127, 128, 255};
        int expv[4] = '{0, 254, 254, 0};
        do_reset();
        shape = 2'd2;
        En = 1'b1;
        rx_log.delete();
        vc = valid_count;
        repeat (256) pulse(3);
        wait_drain();
        checks++;
        if (valid_count - vc != 256) begin errors++; $display("FAIL tri_pulses: got %0d, required 256", valid_count - vc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_log[pos[i]] !== 8'(expv[i])) begin
                errors++;
                $display("FAIL tri_idx%0d: got %0d, required %0d", pos[i], rx_log[pos[i]], expv[i]);
            end
        end
    endtask

    task automatic test_sine();
        int pos [5] = '{0, 32, 64, 128, 192};
`ifdef WAVE_SINE_EN
        int expv[5] = '{128, 218, 255, 128, 1};
`else
        int expv[5] = '{0, 64, 128, 254, 126};
`endif
        do_reset();
        shape = 2'd3;
        En = 1'b1;
        rx_log.delete();
        repeat (256) pulse(3);
        wait_drain();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_log[pos[i]] !== 8'(expv[i])) begin
                errors++;
                $display("FAIL shape3_idx%0d: got %0d, required %0d", pos[i], rx_log[pos[i]], expv[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        int vc;
        do_reset();
        shape = 2'd0;
        En = 1'b1;
        repeat (100) pulse(3);
        wait_drain();
        vc = valid_count;
        En = 1'b0;
        repeat (10) pulse(3);
        checks++;
        if (valid_count != vc) begin errors++; $display("FAIL en_low_pulses: got %0d, required 0", valid_count - vc); end
        En = 1'b1;
        rx_log.delete();
        pulse(3);
        wait_drain();
        checks++;
        if (rx_log[0] !== 8'd255) begin errors++; $display("FAIL en_resume: got %0d, required 255", rx_log[0]); end
    endtask

    task automatic test_reset_mid();
        logic v3, v4, v5;
        logic [7:0] s5;
        do_reset();
        shape = 2'd0;
        En = 1'b1;
        repeat (200) pulse(3);
        wait_drain();
        Clk_div = 1'b1;
        step();
        Rst = 1'b1;
        sb.delete();
        step();
        Rst = 1'b0;
        m_idx = 0;
        push_expected();
        @(negedge Clk_in);
        checks++;
        if (sample !== 8'd0) begin errors++; $display("FAIL rstmid_sample: got %0d, required 0", sample); end
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b, required 0", sample_valid); end
        @(negedge Clk_in); v3 = sample_valid;
        @(negedge Clk_in); v4 = sample_valid;
        @(negedge Clk_in); v5 = sample_valid; s5 = sample;
        checks++;
        if ({v3, v4, v5} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_edge_timing: got valid seq=%b, required 001", {v3, v4, v5});
        end
        checks++;
        if (s5 !== 8'd255) begin errors++; $display("FAIL rstmid_first: got %0d, required 255", s5); end
        step();
        Clk_div = 1'b0;
        repeat (3) step();
        wait_drain();
    endtask

    task automatic test_shape_switch();
        do_reset();
        En = 1'b1;
        for (int i = 0; i < 12; i++) begin
            shape = 2'(i % 4);
            pulse(3);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        shape = 2'd1;
        En = 1'b1;
        repeat (20) pulse(2);
        wait_drain();
    endtask

    initial begin
        step();
        test_reset();
        test_latency();
        test_sawtooth();
        test_triangle();
        test_sine();
        test_enable_hold();
        test_reset_mid();
        test_shape_switch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
